// File: rtl/seq_timer_pkg.sv
// Shared types and defaults for the serial-start sequence timer.
package seq_timer_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned PAT_W_DEF       = 4;
  localparam logic [3:0]  PATTERN_DEF     = 4'b1101;
  localparam int unsigned DLY_W_DEF       = 4;
  localparam int unsigned UNIT_CYCLES_DEF = 1000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned ctr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_timer_ctrl_if.sv
// Host-side serial command / timer status bundle.
interface seq_timer_ctrl_if #(
  parameter int unsigned DLY_W = 4
);
  logic             data;
  logic             ack;
  logic [DLY_W-1:0] count;
  logic             counting;
  logic             done;

  modport master (output data, ack, input count, counting, done);
  modport slave  (input data, ack, output count, counting, done);
endinterface

// File: rtl/seq_pattern_det.sv
// Serial start-pattern detector: history shift register with clear, overlap-aware match.
module seq_pattern_det #(
  parameter int unsigned            PAT_W   = 4,
  parameter logic [PAT_W-1:0]       PATTERN = 4'b1101
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic data_i,
  output logic match_c_o
);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_d;
  logic [PAT_W-1:0] window_c;

  // Window includes the bit arriving this cycle so a match fires on the last pattern bit.
  assign window_c  = {hist_q[PAT_W-2:0], data_i};
  assign match_c_o = en_i && (window_c == PATTERN);

  always_comb begin
    hist_d = hist_q;
    if (clr_i) begin
      hist_d = '0;
    end else if (en_i) begin
      hist_d = window_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/seq_timer_ctrl.sv
// Sequence timer: find start pattern, shift in a delay, count (delay+1) units, hold done until ack.
module seq_timer_ctrl
  import seq_timer_pkg::*;
#(
  parameter int unsigned      PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN     = PATTERN_DEF,
  parameter int unsigned      DLY_W       = DLY_W_DEF,
  parameter int unsigned      UNIT_CYCLES = UNIT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  seq_timer_ctrl_if.slave tmr_if
);

  localparam int unsigned UC_W = ctr_w(UNIT_CYCLES);
  localparam int unsigned BC_W = ctr_w(DLY_W);
  localparam logic [UC_W-1:0] UNIT_RELOAD = UC_W'(UNIT_CYCLES - 1);
  localparam logic [BC_W-1:0] BIT_LAST    = BC_W'(DLY_W - 1);

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic [DLY_W-1:0] count_q, count_d;
  logic [UC_W-1:0]  unit_q, unit_d;
  logic             counting_q, counting_d;
  logic             done_q, done_d;
  logic             match_c;

  // History is held clear outside SEARCH, so every entry to SEARCH starts from zero.
  seq_pattern_det #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_det (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q != SEARCH),
    .en_i      (state_q == SEARCH),
    .data_i    (tmr_if.data),
    .match_c_o (match_c)
  );

  // Next-state, delay/count register and unit counter.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    count_d    = count_q;
    unit_d     = unit_q;
    counting_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      SEARCH: begin
        bit_d = '0;
        if (match_c) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        count_d = {count_q[DLY_W-2:0], tmr_if.data};
        bit_d   = bit_q + BC_W'(1);
        if (bit_q == BIT_LAST) begin
          state_d = COUNT;
          unit_d  = UNIT_RELOAD;
          bit_d   = '0;
        end
      end
      COUNT: begin
        if (unit_q == '0) begin
          if (count_q != '0) begin
            count_d = count_q - DLY_W'(1);
            unit_d  = UNIT_RELOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          unit_d = unit_q - UC_W'(1);
        end
      end
      DONE: begin
        if (tmr_if.ack) begin
          state_d = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    counting_d = (state_d == COUNT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      bit_q      <= '0;
      count_q    <= '0;
      unit_q     <= '0;
      counting_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      count_q    <= count_d;
      unit_q     <= unit_d;
      counting_q <= counting_d;
      done_q     <= done_d;
    end
  end

  assign tmr_if.count    = count_q;
  assign tmr_if.counting = counting_q;
  assign tmr_if.done     = done_q;

endmodule

// File: tb/tb_seq_timer_ctrl.sv
// Bench: two timers (1000-cycle and 4-cycle units) fed identical stimulus, each checked against a phase model.
module tb_seq_timer_ctrl;

  localparam int unsigned DW  = 4;
  localparam int          PAT = 13;

  logic clk = 1'b0;
  logic rst;
  logic data;
  logic ack;

  always #5 clk = ~clk;

  seq_timer_ctrl_if #(.DLY_W(DW)) bus_a ();
  seq_timer_ctrl_if #(.DLY_W(DW)) bus_b ();

  assign bus_a.data = data;
  assign bus_a.ack  = ack;
  assign bus_b.data = data;
  assign bus_b.ack  = ack;

  seq_timer_ctrl #(.PAT_W(4), .PATTERN(4'b1101), .DLY_W(DW), .UNIT_CYCLES(1000)) u_dut_a (
    .clk    (clk),
    .reset  (rst),
    .tmr_if (bus_a)
  );

  seq_timer_ctrl #(.PAT_W(4), .PATTERN(4'b1101), .DLY_W(DW), .UNIT_CYCLES(4)) u_dut_b (
    .clk    (clk),
    .reset  (rst),
    .tmr_if (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 hunting, 1 loading delay, 2 timing, 3 waiting for ack.
  int unsigned unit_len [2] = '{1000, 4};
  int phase   [2];
  int hist    [2];
  int cnt     [2];
  int nbits   [2];
  int elapsed [2];
  int total   [2];
  int dly     [2];
  int run     [2];
  int want_len[2];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int k, input bit d, input bit a, input bit r);
    want_len[k] = -1;
    if (r) begin
      phase[k] = 0; hist[k] = 0; cnt[k] = 0; run[k] = 0;
      return;
    end
    case (phase[k])
      0: begin
        hist[k] = ((hist[k] << 1) | int'(d)) & 15;
        if (hist[k] == PAT) begin
          phase[k] = 1;
          nbits[k] = 0;
        end
      end
      1: begin
        cnt[k] = ((cnt[k] << 1) | int'(d)) & 15;
        nbits[k]++;
        if (nbits[k] == DW) begin
          phase[k]   = 2;
          dly[k]     = cnt[k];
          elapsed[k] = 0;
          total[k]   = (cnt[k] + 1) * int'(unit_len[k]);
        end
      end
      2: begin
        elapsed[k]++;
        if (elapsed[k] == total[k]) begin
          phase[k]    = 3;
          want_len[k] = total[k];
        end else begin
          cnt[k] = dly[k] - elapsed[k] / int'(unit_len[k]);
        end
      end
      default: begin
        if (a) begin
          phase[k] = 0;
          hist[k]  = 0;
        end
      end
    endcase
  endtask

  task automatic sample(input int k, input int unsigned c, input bit cg, input bit dn);
    string nm;
    nm = (k == 0) ? "u1000" : "u4";
    chk({nm, ".count"},    c,  int'(cnt[k]));
    chk({nm, ".counting"}, cg, phase[k] == 2);
    chk({nm, ".done"},     dn, phase[k] == 3);
    if (want_len[k] >= 0) begin
      chk({nm, ".run_len"}, run[k], want_len[k]);
      run[k] = 0;
    end
    if (cg) run[k]++;
  endtask

  task automatic step(input bit d, input bit a, input bit r);
    data = d; ack = a; rst = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, d, a, r);
    #1;
    sample(0, bus_a.count, bus_a.counting, bus_a.done);
    sample(1, bus_b.count, bus_b.counting, bus_b.done);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit a);
    for (int i = 0; i < n; i++) step(1'b0, a, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; hist[k] = 0; cnt[k] = 0; run[k] = 0; want_len[k] = -1;
    end
    data = 1'b0; ack = 1'b0; rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Delay 2 on 1000-cycle units: 3000 counting cycles.
    send_bits(8'b1101_0010, 8);
    idle(3003, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Overlapping pattern then delay 0.
    send_bits(8'b0001_1101, 5);
    send_bits(8'b0000_0000, 4);
    idle(1005, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Near-miss stream stays in search.
    for (int i = 0; i < 10; i++) send_bits(8'b1100_1100, 8);

    // done held without ack while data shows the pattern; ack pulse mid-count.
    send_bits(8'b1101_0000, 8);
    idle(6, 1'b0);
    for (int i = 0; i < 5; i++) send_bits(8'b0000_1101, 4);
    step(1'b0, 1'b1, 1'b0);
    send_bits(8'b1101_0001, 8);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(6, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Reset mid-count, then a bare tail must not match.
    step(1'b0, 1'b0, 1'b1);
    send_bits(8'b1101_0101, 8);
    idle(6, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    send_bits(8'b0000_0101, 3);
    idle(4, 1'b0);

    // Full-scale delay on 4-cycle units: 64 counting cycles.
    send_bits(8'b1101_1111, 8);
    idle(66, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Ack held high into done gives a one-cycle done.
    send_bits(8'b1101_0000, 8);
    idle(6, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic with occasional pattern bursts and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        send_bits({4'b1101, 4'($urandom)}, 8);
      end else begin
        step(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
